// File: rtl/rmii_tx_if.sv
// Byte stream feeding the RMII transmitter.
// Handshake: a byte moves on a rising edge where s_valid && s_ready; s_ready
// is offered only in the single accept slot per byte and is never held open.
interface rmii_tx_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/rmii_tx.sv
// RMII frame transmitter: preamble/SFD, payload with zero pad, CRC-32 FCS, IPG.
// The line outputs are registered from the next-state values, so they line up with the state register.
module rmii_tx #(
  parameter int MIN_FRAME = 60,
  parameter int IPG_BYTES = 12
) (
  input  logic       eth_clk,
  input  logic       rst,
  rmii_tx_if.slave   s,
  output logic [1:0] eth_txd,
  output logic       eth_txen,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SFD      = 3'd2,
    S_DATA     = 3'd3,
    S_PAD      = 3'd4,
    S_FCS      = 3'd5,
    S_IPG      = 3'd6
  } state_t;

  localparam int          IPG_CYC  = IPG_BYTES * 4;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_dib, w_dib_nxt;
  logic [15:0] r_cyc, w_cyc_nxt;
  logic [10:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]  r_byte, w_byte_nxt;
  logic        r_last, w_last_nxt;
  logic [31:0] r_crc, w_crc_nxt, w_crc_upd;
  logic [1:0]  r_txd, w_txd_nxt;
  logic        r_txen, w_txen_nxt;
  logic        r_frame_done, w_frame_done_nxt;
  logic [1:0]  w_cur_dibit;
  logic        w_ready;
  logic        w_below_min;

  // Reflected CRC-32 advanced by one dibit, bit 0 of the dibit first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 2; i++) begin
      if (x[0] ^ d[i]) x = (x >> 1) ^ CRC_POLY;
      else             x = x >> 1;
    end
    return x;
  endfunction

  assign w_cur_dibit = r_byte[{r_dib, 1'b0} +: 2];
  assign w_crc_upd   = crc_dibit(r_crc, w_cur_dibit);
  assign w_cnt_inc   = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
  assign w_below_min = ({21'd0, w_cnt_inc} < 32'(MIN_FRAME));

  // Accept slot: last dibit of SFD, or last dibit of a byte that was not the final one.
  assign w_ready = (r_dib == 2'd3) &&
                   ((r_state == S_SFD) || ((r_state == S_DATA) && !r_last));

  always_comb begin
    w_state_nxt      = r_state;
    w_dib_nxt        = r_dib;
    w_cyc_nxt        = r_cyc;
    w_cnt_nxt        = r_cnt;
    w_byte_nxt       = r_byte;
    w_last_nxt       = r_last;
    w_crc_nxt        = r_crc;
    w_frame_done_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_crc_nxt = CRC_INIT;
        if (s.s_valid) begin
          w_state_nxt = S_PREAMBLE;
          w_cyc_nxt   = 16'd0;
          w_dib_nxt   = 2'd0;
          w_cnt_nxt   = 11'd0;
        end
      end

      S_PREAMBLE: begin
        w_crc_nxt = CRC_INIT;
        if (r_cyc == 16'd27) begin
          w_state_nxt = S_SFD;
          w_cyc_nxt   = 16'd0;
          w_dib_nxt   = 2'd0;
        end else begin
          w_cyc_nxt = r_cyc + 16'd1;
        end
      end

      S_SFD: begin
        w_crc_nxt = CRC_INIT;
        w_dib_nxt = r_dib + 2'd1;
        if (r_dib == 2'd3) begin
          if (s.s_valid) begin
            w_state_nxt = S_DATA;
            w_byte_nxt  = s.s_data;
            w_last_nxt  = s.s_last;
          end else begin
            w_state_nxt = S_IPG;
            w_cyc_nxt   = 16'd0;
          end
        end
      end

      S_DATA: begin
        w_crc_nxt = w_crc_upd;
        w_dib_nxt = r_dib + 2'd1;
        if (r_dib == 2'd3) begin
          w_cnt_nxt = w_cnt_inc;
          if (!r_last) begin
            if (s.s_valid) begin
              w_byte_nxt = s.s_data;
              w_last_nxt = s.s_last;
            end else begin
              w_state_nxt = S_IPG;
              w_cyc_nxt   = 16'd0;
            end
          end else if (w_below_min) begin
            w_state_nxt = S_PAD;
            w_byte_nxt  = 8'h00;
          end else begin
            w_state_nxt = S_FCS;
            w_cyc_nxt   = 16'd0;
          end
        end
      end

      S_PAD: begin
        w_crc_nxt = w_crc_upd;
        w_dib_nxt = r_dib + 2'd1;
        if (r_dib == 2'd3) begin
          w_cnt_nxt = w_cnt_inc;
          if (!w_below_min) begin
            w_state_nxt = S_FCS;
            w_cyc_nxt   = 16'd0;
          end
        end
      end

      S_FCS: begin
        w_dib_nxt = r_dib + 2'd1;
        if (r_cyc == 16'd15) begin
          w_state_nxt      = S_IPG;
          w_cyc_nxt        = 16'd0;
          w_frame_done_nxt = 1'b1;
        end else begin
          w_cyc_nxt = r_cyc + 16'd1;
        end
      end

      S_IPG: begin
        if (r_cyc == 16'(IPG_CYC - 1)) begin
          w_cyc_nxt = 16'd0;
          w_dib_nxt = 2'd0;
          w_cnt_nxt = 11'd0;
          // A waiting frame starts straight out of the gap so the gap stays exact.
          w_state_nxt = s.s_valid ? S_PREAMBLE : S_IDLE;
        end else begin
          w_cyc_nxt = r_cyc + 16'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_txd_nxt  = 2'b00;
    w_txen_nxt = 1'b0;
    unique case (w_state_nxt)
      S_PREAMBLE: begin
        w_txen_nxt = 1'b1;
        w_txd_nxt  = 2'b01;
      end
      S_SFD: begin
        w_txen_nxt = 1'b1;
        w_txd_nxt  = (w_dib_nxt == 2'd3) ? 2'b11 : 2'b01;
      end
      S_DATA, S_PAD: begin
        w_txen_nxt = 1'b1;
        w_txd_nxt  = w_byte_nxt[{w_dib_nxt, 1'b0} +: 2];
      end
      S_FCS: begin
        w_txen_nxt = 1'b1;
        w_txd_nxt  = ~w_crc_nxt[{w_cyc_nxt[3:0], 1'b0} +: 2];
      end
      default: begin
        w_txen_nxt = 1'b0;
        w_txd_nxt  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge eth_clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_dib        <= 2'd0;
      r_cyc        <= 16'd0;
      r_cnt        <= 11'd0;
      r_byte       <= 8'h00;
      r_last       <= 1'b0;
      r_crc        <= CRC_INIT;
      r_txd        <= 2'b00;
      r_txen       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dib        <= w_dib_nxt;
      r_cyc        <= w_cyc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_byte       <= w_byte_nxt;
      r_last       <= w_last_nxt;
      r_crc        <= w_crc_nxt;
      r_txd        <= w_txd_nxt;
      r_txen       <= w_txen_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign s.s_ready  = w_ready;
  assign eth_txd    = r_txd;
  assign eth_txen   = r_txen;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign underrun   = w_ready & ~s.s_valid;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_rmii_tx.sv
// Directed bench for rmii_tx: one DUT with MIN_FRAME=0 for the CRC vector, one with defaults.
module tb_rmii_tx;

  logic       eth_clk;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       sel;

  logic [1:0] txd0, txd1;
  logic       txen0, txen1, busy0, busy1, done0, done1, und0, und1;
  logic [2:0] st0, st1;

  rmii_tx_if sif0 ();
  rmii_tx_if sif1 ();

  assign sif0.s_data  = s_data;
  assign sif0.s_last  = s_last;
  assign sif0.s_valid = s_valid & sel;
  assign sif1.s_data  = s_data;
  assign sif1.s_last  = s_last;
  assign sif1.s_valid = s_valid & ~sel;

  rmii_tx #(.MIN_FRAME(0), .IPG_BYTES(12)) dut0 (
    .eth_clk(eth_clk), .rst(rst), .s(sif0),
    .eth_txd(txd0), .eth_txen(txen0), .busy(busy0),
    .frame_done(done0), .underrun(und0), .dbg_state(st0)
  );

  rmii_tx dut1 (
    .eth_clk(eth_clk), .rst(rst), .s(sif1),
    .eth_txd(txd1), .eth_txen(txen1), .busy(busy1),
    .frame_done(done1), .underrun(und1), .dbg_state(st1)
  );

  // sel=1 observes dut0, sel=0 observes dut1
  wire [1:0] m_txd   = sel ? txd0 : txd1;
  wire       m_txen  = sel ? txen0 : txen1;
  wire       m_busy  = sel ? busy0 : busy1;
  wire       m_done  = sel ? done0 : done1;
  wire       m_under = sel ? und0 : und1;
  wire       m_ready = sel ? sif0.s_ready : sif1.s_ready;
  wire [2:0] m_state = sel ? st0 : st1;

  int total = 0;
  int bad   = 0;

  logic [7:0] fb [0:127];
  logic [1:0] cap_q[$];
  int         gap_q[$];
  logic       ua_q[$];
  int n_txen = 0, n_ready = 0, n_done = 0, n_under = 0, n_busy_low = 0;
  int low_run = 0;
  bit seen_high = 1'b0;
  bit prev_under = 1'b0;
  int ref_base = 0;

  initial eth_clk = 1'b0;
  always #10 eth_clk = ~eth_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line monitor for the selected DUT, sampled away from the active edge.
  always @(negedge eth_clk) begin
    if (m_txen) begin
      cap_q.push_back(m_txd);
      n_txen <= n_txen + 1;
      if (seen_high && low_run != 0) gap_q.push_back(low_run);
      low_run   <= 0;
      seen_high <= 1'b1;
    end else if (seen_high) begin
      low_run <= low_run + 1;
    end
    if (m_ready)           n_ready    <= n_ready + 1;
    if (m_done)            n_done     <= n_done + 1;
    if (m_under)           n_under    <= n_under + 1;
    if (m_busy && !m_txen) n_busy_low <= n_busy_low + 1;
    if (prev_under) ua_q.push_back(m_txen);
    prev_under <= m_under;
  end

  function automatic logic [7:0] cap_byte(input int d);
    return {cap_q[d+3], cap_q[d+2], cap_q[d+1], cap_q[d]};
  endfunction

  function automatic logic [31:0] residue(input int d, input int nbytes);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < nbytes; k++) begin
      b = cap_byte(d + 4 * k);
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ b[j]) c = (c >> 1) ^ 32'hEDB88320;
        else             c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic drive_frame(input int n, input int stop_after, input bit hold);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    s_data  = fb[0];
    s_last  = (n == 1);
    s_valid = 1'b1;
    while (idx < stop_after && guard < 3000) begin
      @(negedge eth_clk);
      guard++;
      if (m_ready) begin
        idx++;
        @(posedge eth_clk);
        #1;
        if (idx < stop_after) begin
          s_data = fb[idx];
          s_last = (idx == n - 1);
        end
      end
    end
    if (idx < stop_after) begin
      total++; bad++;
      $display("FAIL drive_timeout: accepted %0d bytes, need %0d", idx, stop_after);
    end
    s_valid = hold;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge eth_clk);
      g++;
    end while (m_busy && g < 3000);
    if (m_busy) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", g);
    end
    repeat (2) @(negedge eth_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; sel = 1'b0;
    repeat (3) @(negedge eth_clk);
    total++; if (txen1 !== 1'b0)         begin bad++; $display("FAIL rst_txen got=%b exp=0", txen1); end
    total++; if (txd1 !== 2'b00)         begin bad++; $display("FAIL rst_txd got=%b exp=00", txd1); end
    total++; if (sif1.s_ready !== 1'b0)  begin bad++; $display("FAIL rst_ready got=%b exp=0", sif1.s_ready); end
    total++; if (busy1 !== 1'b0)         begin bad++; $display("FAIL rst_busy got=%b exp=0", busy1); end
    total++; if (done1 !== 1'b0)         begin bad++; $display("FAIL rst_done got=%b exp=0", done1); end
    total++; if (und1 !== 1'b0)          begin bad++; $display("FAIL rst_under got=%b exp=0", und1); end
    total++; if (txen0 !== 1'b0)         begin bad++; $display("FAIL rst_txen0 got=%b exp=0", txen0); end
    total++; if (busy0 !== 1'b0)         begin bad++; $display("FAIL rst_busy0 got=%b exp=0", busy0); end
    rst = 1'b0;
    repeat (2) @(negedge eth_clk);
  endtask

  task automatic test_crc_vector();
    int base, t0, r0, d0, nb;
    logic [7:0] fcs_exp [0:3];
    fcs_exp[0] = 8'h26; fcs_exp[1] = 8'h39; fcs_exp[2] = 8'hF4; fcs_exp[3] = 8'hCB;
    sel = 1'b1;
    @(negedge eth_clk);
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    base = cap_q.size(); t0 = n_txen; r0 = n_ready; d0 = n_done;
    drive_frame(9, 9, 1'b0);
    wait_idle();
    total++; if (n_txen - t0 != 84) begin bad++; $display("FAIL crc_txen_cycles got=%0d exp=84", n_txen - t0); end
    total++; if (n_ready - r0 != 9) begin bad++; $display("FAIL crc_ready_count got=%0d exp=9", n_ready - r0); end
    total++; if (n_done - d0 != 1)  begin bad++; $display("FAIL crc_frame_done got=%0d exp=1", n_done - d0); end
    if (cap_q.size() - base >= 84) begin
      for (int i = 0; i < 32; i++) begin
        total++;
        if (cap_q[base+i] !== ((i == 31) ? 2'b11 : 2'b01)) begin
          bad++; $display("FAIL preamble_sfd dibit %0d got=%b exp=%b", i, cap_q[base+i], (i == 31) ? 2'b11 : 2'b01);
        end
      end
      nb = 0;
      for (int k = 0; k < 9; k++) if (cap_byte(base + 32 + 4 * k) !== fb[k]) nb++;
      total++; if (nb != 0) begin bad++; $display("FAIL crc_payload bad_bytes=%0d exp=0", nb); end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (cap_byte(base + 68 + 4 * k) !== fcs_exp[k]) begin
          bad++; $display("FAIL crc_fcs byte %0d got=%h exp=%h", k, cap_byte(base + 68 + 4 * k), fcs_exp[k]);
        end
      end
    end
    sel = 1'b0;
    @(negedge eth_clk);
  endtask

  task automatic test_pad();
    int base, t0, r0, d0, nz;
    fb[0] = 8'hAA;
    base = cap_q.size(); t0 = n_txen; r0 = n_ready; d0 = n_done;
    ref_base = base;
    drive_frame(1, 1, 1'b0);
    wait_idle();
    total++; if (n_txen - t0 != 288) begin bad++; $display("FAIL pad_txen_cycles got=%0d exp=288", n_txen - t0); end
    total++; if (n_ready - r0 != 1)  begin bad++; $display("FAIL pad_ready_count got=%0d exp=1", n_ready - r0); end
    total++; if (n_done - d0 != 1)   begin bad++; $display("FAIL pad_frame_done got=%0d exp=1", n_done - d0); end
    if (cap_q.size() - base >= 288) begin
      total++; if (cap_byte(base + 32) !== 8'hAA) begin bad++; $display("FAIL pad_first_byte got=%h exp=aa", cap_byte(base + 32)); end
      nz = 0;
      for (int k = 1; k < 60; k++) if (cap_byte(base + 32 + 4 * k) !== 8'h00) nz++;
      total++; if (nz != 0) begin bad++; $display("FAIL pad_zero_bytes nonzero=%0d exp=0", nz); end
      total++;
      if (residue(base + 32, 64) !== 32'hDEBB20E3) begin
        bad++; $display("FAIL pad_crc_residue got=%h exp=debb20e3", residue(base + 32, 64));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0, r0, d0;
    for (int i = 0; i < 64; i++) fb[i] = 8'(i * 3 + 1);
    t0 = n_txen; r0 = n_ready; d0 = n_done;
    drive_frame(64, 64, 1'b1);
    drive_frame(64, 64, 1'b0);
    wait_idle();
    total++; if (n_txen - t0 != 608) begin bad++; $display("FAIL b2b_txen_cycles got=%0d exp=608", n_txen - t0); end
    total++; if (n_ready - r0 != 128) begin bad++; $display("FAIL b2b_ready_count got=%0d exp=128", n_ready - r0); end
    total++; if (n_done - d0 != 2)    begin bad++; $display("FAIL b2b_frame_done got=%0d exp=2", n_done - d0); end
    total++;
    if (gap_q.size() == 0 || gap_q[gap_q.size()-1] != 48) begin
      bad++; $display("FAIL b2b_gap got=%0d exp=48", (gap_q.size() == 0) ? -1 : gap_q[gap_q.size()-1]);
    end
  endtask

  task automatic test_underrun();
    int t0, u0, d0, b0, q0;
    for (int i = 0; i < 20; i++) fb[i] = 8'hC0 + 8'(i);
    t0 = n_txen; u0 = n_under; d0 = n_done; b0 = n_busy_low; q0 = ua_q.size();
    drive_frame(20, 9, 1'b0);
    wait_idle();
    total++; if (n_under - u0 != 1)     begin bad++; $display("FAIL und_pulses got=%0d exp=1", n_under - u0); end
    total++;
    if (ua_q.size() != q0 + 1 || ua_q[ua_q.size()-1] !== 1'b0) begin
      bad++; $display("FAIL und_txen_next got_entries=%0d exp_entries=1", ua_q.size() - q0);
    end
    total++; if (n_txen - t0 != 68)     begin bad++; $display("FAIL und_txen_cycles got=%0d exp=68", n_txen - t0); end
    total++; if (n_busy_low - b0 != 48) begin bad++; $display("FAIL und_ipg_cycles got=%0d exp=48", n_busy_low - b0); end
    total++; if (n_done - d0 != 0)      begin bad++; $display("FAIL und_frame_done got=%0d exp=0", n_done - d0); end
  endtask

  task automatic test_reset_midframe();
    int g, d0, u0, base, t0, mism;
    fb[0] = 8'hAA;
    d0 = n_done; u0 = n_under;
    drive_frame(1, 1, 1'b0);
    g = 0;
    while (m_state != 3'd5 && g < 1000) begin
      @(negedge eth_clk);
      g++;
    end
    total++; if (m_state !== 3'd5) begin bad++; $display("FAIL mid_reach_fcs state=%0d exp=5", m_state); end
    rst = 1'b1;
    @(negedge eth_clk);
    total++; if (m_txen !== 1'b0) begin bad++; $display("FAIL mid_txen got=%b exp=0", m_txen); end
    total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", m_busy); end
    rst = 1'b0;
    repeat (4) @(negedge eth_clk);
    total++; if (n_done - d0 != 0)  begin bad++; $display("FAIL mid_no_done got=%0d exp=0", n_done - d0); end
    total++; if (n_under - u0 != 0) begin bad++; $display("FAIL mid_no_under got=%0d exp=0", n_under - u0); end
    base = cap_q.size(); t0 = n_txen;
    drive_frame(1, 1, 1'b0);
    wait_idle();
    total++; if (n_txen - t0 != 288) begin bad++; $display("FAIL mid_refr_cycles got=%0d exp=288", n_txen - t0); end
    if (cap_q.size() - base >= 288) begin
      mism = 0;
      for (int i = 0; i < 288; i++) if (cap_q[base+i] !== cap_q[ref_base+i]) mism++;
      total++; if (mism != 0) begin bad++; $display("FAIL mid_refr_bits diff_dibits=%0d exp=0", mism); end
    end
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    test_pad();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rmii_tx.md
RMII_TX -- requirements
Module: rmii_tx

Interface
REQ-001 Parameter MIN_FRAME, default 60: minimum bytes sent before FCS (payload plus zero pad).
REQ-002 Parameter IPG_BYTES, default 12: inter-packet gap in byte times (4 eth_clk each).
REQ-003 Port list:
- eth_clk  in  1  50 MHz RMII reference clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  8  payload byte (destination MAC first; no preamble, SFD or FCS).
- s_valid  in  1  s_data valid.
- s_last  in  1  s_data is the final payload byte of the frame.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- eth_txd  out  2  RMII transmit dibit, registered.
- eth_txen  out  1  RMII transmit enable, registered.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the first IPG cycle after a good frame.
- underrun  out  1  one-cycle pulse when a frame is aborted for missing data.

Function
REQ-004 FSM states: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IPG.
REQ-005 Each byte is sent as 4 dibits, one per eth_clk, LSB pair first (bits [1:0], [3:2], [5:4], [7:6]); a 2-bit dibit counter orders the pairs.
REQ-006 IDLE: eth_txen=0, eth_txd=00, s_ready=0. When s_valid=1, the FSM enters PREAMBLE on the next edge.
REQ-007 PREAMBLE: 28 cycles, eth_txd=01, eth_txen=1.
REQ-008 SFD (0xD5): 4 cycles, dibits 01,01,01,11. Cycle 1 of eth_txen is the first preamble dibit, so the first payload dibit appears in cycle 33.
REQ-009 s_ready is high only in the final dibit cycle of SFD and of each DATA byte whose s_last was 0; it is low in all other cycles.
REQ-010 If s_valid=0 while s_ready=1, the block aborts: pulse underrun, drop eth_txen the next cycle, then enter IPG. No FCS is sent.
REQ-011 The byte counter is 11 bits wide and counts payload and pad bytes sent. It saturates at 2047 and has no maximum-length enforcement.
REQ-012 After the byte accepted with s_last=1 is sent:
- If byte count < MIN_FRAME, enter PAD and send 0x00 bytes until count = MIN_FRAME.
- Otherwise enter FCS.
REQ-013 CRC-32 uses the reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at SFD. It is updated 2 bits per cycle over the DATA and PAD dibits only.
REQ-014 FCS: send ~crc in 4 bytes, ~crc[7:0] first, using the dibit order of REQ-005 (16 cycles). The CRC register is frozen during FCS.
REQ-015 IPG: IPG_BYTES*4 cycles with eth_txen=0 and eth_txd=00.
- frame_done pulses in the first IPG cycle after FCS.
- After the gap, go to IDLE. If s_valid=1, PREAMBLE starts on the next edge (back-to-back frames).
REQ-016 s_data, s_valid and s_last are ignored outside accept cycles.
REQ-017 Total eth_txen high cycles for a good frame = 4*(8 + max(N, MIN_FRAME) + 4), where N is the payload length.

Reset
REQ-018 While rst=1 at an edge:
- Outputs go to eth_txen=0, eth_txd=00, s_ready=0, busy=0, frame_done=0, underrun=0.
- FSM goes to IDLE; counters clear; CRC goes to 0xFFFFFFFF.
REQ-019 Reset mid-frame truncates immediately with no IPG and no pulses. A new frame may start on the first edge after rst falls.

Verification
REQ-020 With MIN_FRAME=0, send payload "123456789" (0x31..0x39) -> FCS bytes on wire 26 39 F4 CB; eth_txen high 84 cycles.
REQ-021 With default parameters, send a 1-byte payload 0xAA -> 59 pad bytes of 0x00 follow; eth_txen high 288 cycles. Running reflected CRC over data plus FCS (excluding the final complement) equals 0xDEBB20E3.
REQ-022 Two 64-byte frames with s_valid held high throughout -> exactly 48 eth_txen-low cycles between frames; one frame_done pulse per frame.
REQ-023 Drop s_valid at the accept slot of byte 10 -> underrun pulses once and eth_txen falls the next cycle. No FCS is sent; 48 idle cycles follow before busy=0.
REQ-024 Assert rst for 1 cycle during the FCS of a frame -> next cycle eth_txen=0 and busy=0. A frame started after reset is bit-exact to REQ-021.
REQ-025 Check the preamble/SFD dibit sequence (28 of 01, then 01,01,01,11) and that s_ready is asserted exactly N times per N-byte frame.
